// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: per-channel divide/phase, realign on every reconfiguration, lock handshake.
// Optional macro CLK_EN_GEN_GATE_EN forces outen/outclk low whenever locked is low.
module clk_en_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DIV_RST     = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] outen,
  output logic [NUM_CH-1:0] outclk,
  output logic              locked
);

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  // Handshake: a transfer happens on a refclk edge where cfg_valid && cfg_ready;
  // cfg_ready is high only in LOCKED, and the master holds cfg_* stable until then.
  typedef enum logic [1:0] {ST_RST, ST_ALIGN, ST_SETTLE, ST_LOCKED} state_t;

  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic             locked_q;
  logic             xfer;
  logic             cfg_hit;
  logic [DIV_W-1:0] phase_wr;
  logic [NUM_CH-1:0] outen_raw;
  logic [NUM_CH-1:0] outclk_raw;

  assign xfer     = cfg_valid && locked_q;
  assign cfg_hit  = xfer && ({1'b0, cfg_ch} < NUM_CH_V);
  assign phase_wr = (cfg_phase < cfg_div) ? cfg_phase :
                    (cfg_div == '0)       ? '0 : (cfg_div - DIV_W'(1));

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= ST_RST;
      settle_cnt <= '0;
      locked_q   <= 1'b0;
    end else begin
      case (state)
        ST_RST: begin
          state <= ST_ALIGN;
        end
        ST_ALIGN: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state    <= ST_LOCKED;
            locked_q <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        ST_LOCKED: begin
          // Out-of-range channel requests are consumed here without leaving LOCKED.
          if (cfg_hit) begin
            state    <= ST_ALIGN;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RST;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = locked_q;
  assign locked    = locked_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] phase_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W:0]   half;
    logic             en_q;
    logic             clk_q;

    assign half = ({1'b0, div_q} + (DIV_W + 1)'(1)) >> 1;

    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        div_q   <= DIV_W'(DIV_RST);
        phase_q <= '0;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        clk_q   <= 1'b0;
      end else begin
        if (cfg_hit && (cfg_ch == CH_W'(i))) begin
          div_q   <= cfg_div;
          phase_q <= phase_wr;
        end
        // ALIGN clears every channel together so all of them restart in step.
        if ((state == ST_ALIGN) || (div_q == '0)) begin
          cnt_q <= '0;
        end else if (cnt_q >= (div_q - DIV_W'(1))) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
        en_q  <= (div_q != '0) && (cnt_q == phase_q);
        clk_q <= (div_q != '0) && ({1'b0, cnt_q} < half);
      end
    end

    assign outen_raw[i]  = en_q;
    assign outclk_raw[i] = clk_q;
  end

`ifdef CLK_EN_GEN_GATE_EN
  assign outen  = outen_raw & {NUM_CH{locked_q}};
  assign outclk = outclk_raw & {NUM_CH{locked_q}};
`else
  assign outen  = outen_raw;
  assign outclk = outclk_raw;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: directed and random reprogramming checked every cycle against a timing model.
module tb_clk_en_gen;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int DIV_RST     = 2;
  localparam int CH_W        = 2;

  logic              refclk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [DIV_W-1:0]  cfg_phase = '0;
  logic [NUM_CH-1:0] outen;
  logic [NUM_CH-1:0] outclk;
  logic              locked;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int align_cyc;
  int m_div[NUM_CH];
  int m_phase[NUM_CH];

  clk_en_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES), .DIV_RST(DIV_RST)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outen(outen), .outclk(outclk), .locked(locked)
  );

  always #5 refclk = ~refclk;

`ifdef CLK_EN_GEN_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Model: after ALIGN at cycle a, divided time starts at cycle a+2.
  function automatic bit model_locked(input int n);
    return n >= align_cyc + LOCK_CYCLES + 1;
  endfunction

  function automatic int clamp_phase(input int d, input int p);
    if (p < d) return p;
    return (d == 0) ? 0 : d - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i]   = DIV_RST;
      m_phase[i] = 0;
    end
    cyc       = 0;
    align_cyc = 1;
  endtask

  task automatic step();
    bit xfer;
    int ch;
    logic [NUM_CH-1:0] exp_en;
    logic [NUM_CH-1:0] exp_clk;
    bit lk;
    int k;
    int r;
    xfer = cfg_valid && model_locked(cyc);
    ch   = int'(cfg_ch);
    @(posedge refclk);
    #1;
    cyc++;
    if (xfer && ch < NUM_CH) begin
      m_div[ch]   = int'(cfg_div);
      m_phase[ch] = clamp_phase(int'(cfg_div), int'(cfg_phase));
      align_cyc   = cyc;
    end
    lk = model_locked(cyc);
    check("locked", 32'(locked), 32'(lk));
    check("cfg_ready", 32'(cfg_ready), 32'(lk));
    exp_en  = '0;
    exp_clk = '0;
    k = cyc - (align_cyc + 2);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_div[i] != 0 && k >= 0) begin
        r = k % m_div[i];
        exp_en[i]  = (r == m_phase[i]);
        exp_clk[i] = (r < (m_div[i] + 1) / 2);
      end
    end
    if (lk || k >= 0 || GATED) begin
      if (GATED && !lk) begin
        exp_en  = '0;
        exp_clk = '0;
      end
      check("outen", 32'(outen), 32'(exp_en));
      check("outclk", 32'(outclk), 32'(exp_clk));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input int ch, input int d, input int p);
    int budget;
    budget    = 200;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(d);
    cfg_phase = DIV_W'(p);
    cfg_valid = 1'b1;
    while (!model_locked(cyc) && budget > 0) begin
      step();
      budget--;
    end
    check("cfg_wait_budget", 32'(budget > 0), 32'd1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outen"}, 32'(outen), 32'd0);
    check({tag, "_outclk"}, 32'(outclk), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_ready"}, 32'(cfg_ready), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();
    run(30);

    // ch1 div 5 phase 3 against ch0 at div 2
    cfg_write(1, 5, 3);
    run(40);

    // phase beyond divide is clamped
    cfg_write(0, 4, 9);
    run(20);

    // special ratios
    cfg_write(2, 0, 0);
    run(5);
    cfg_write(1, 1, 0);
    run(20);

    // out-of-range channel is consumed without disturbing anything
    cfg_write(3, 7, 1);
    run(15);

    // back-to-back request waits through SETTLE
    cfg_write(0, 3, 1);
    cfg_write(2, 6, 5);
    run(25);

    for (int it = 0; it < 8; it++) begin
      cfg_write($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 11));
      run($urandom_range(5, 30));
    end

    // reset in the middle of SETTLE
    cfg_write(0, 7, 2);
    run(5);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst_async");
    @(posedge refclk);
    @(posedge refclk);
    #1;
    check_all_zero("midrst_hold");
    rst = 1'b0;
    model_reset();
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
